int_exec_unit: RTL and testbench

Parametrised integer execution unit for the out-of-order core: one tagged micro-op per cycle in, one tagged result per cycle out on the common data bus. Add, logic, shift, compare and multiply ops run through a fixed-latency pipeline of MUL_STAGES registers. Divide and remainder use an iterative divider that blocks issue while busy. A flush input kills everything in flight.

---
 rtl/exec_pkg.sv | 41 ++++
 rtl/int_divider.sv | 128 ++++++++++++
 rtl/int_exec_unit.sv | 173 +++++++++++++++++
 tb/tb_int_exec_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the integer execution unit: op codes, divider states, helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package exec_pkg;

    localparam int EXEC_OP_W = 5;

    typedef enum logic [EXEC_OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_LUI    = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } exec_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic logic is_div(input exec_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/int_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with sign fix-up and special cases.
// Latency: start at edge t -> result held in DONE after edge t+DATA_WIDTH+2 (fixed, incl. special cases).
// Backpressure: o_busy high in CALC/FIX; a new start is taken only in IDLE or DONE.
module int_divider
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_flush,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic                  i_rem,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    div_state_e            r_state;
    div_state_e            w_next;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_quot;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div0;
    logic                  r_ovf;
    logic                  r_rem_sel;

    logic                  w_accept;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH:0]   w_shift;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_sub;
    logic [DATA_WIDTH-1:0] w_q_fix;
    logic [DATA_WIDTH-1:0] w_r_fix;

    assign w_accept = i_start && !i_flush && ((r_state == DIV_IDLE) || (r_state == DIV_DONE));
    assign w_a_neg  = i_signed & i_a[DATA_WIDTH-1];
    assign w_b_neg  = i_signed & i_b[DATA_WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // One restoring step: shift the next dividend bit into the partial remainder.
    // The true difference is below the divisor whenever w_ge holds, so DATA_WIDTH bits suffice.
    assign w_shift  = {r_rem, r_quot[DATA_WIDTH-1]};
    assign w_ge     = w_shift >= {1'b0, r_divisor};
    assign w_sub    = w_shift[DATA_WIDTH-1:0] - r_divisor;

    assign w_q_fix  = r_neg_q ? -r_quot : r_quot;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

    assign o_busy   = (r_state == DIV_CALC) || (r_state == DIV_FIX);
    assign o_done   = (r_state == DIV_DONE);
    assign o_result = r_result;

    // State register; reset takes priority over flush, both land in IDLE.
    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: CALC holds one extra cycle after the last iteration so latency is DATA_WIDTH+2.
    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: if (i_start) w_next = DIV_CALC;
            DIV_CALC: if (r_cnt == CW'(DATA_WIDTH)) w_next = DIV_FIX;
            DIV_FIX:  w_next = DIV_DONE;
            DIV_DONE: w_next = i_start ? DIV_CALC : DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    // Datapath: load magnitudes on start, iterate in CALC, apply sign and special cases in FIX.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_a       <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_rem_sel <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_quot    <= w_a_mag;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
            r_a       <= i_a;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_div0    <= (i_b == '0);
            r_ovf     <= i_signed && (i_a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (i_b == '1);
            r_rem_sel <= i_rem;
        end else if ((r_state == DIV_CALC) && (r_cnt != CW'(DATA_WIDTH))) begin
            r_cnt  <= r_cnt + CW'(1);
            r_quot <= {r_quot[DATA_WIDTH-2:0], w_ge};
            r_rem  <= w_ge ? w_sub : w_shift[DATA_WIDTH-1:0];
        end else if (r_state == DIV_FIX) begin
            if (r_div0) begin
                r_result <= r_rem_sel ? r_a : '1;
            end else if (r_ovf) begin
                r_result <= r_rem_sel ? '0 : r_a;
            end else begin
                r_result <= r_rem_sel ? w_r_fix : w_q_fix;
            end
        end
    end

endmodule

// File: rtl/int_exec_unit.sv
// Integer execution unit: tagged ALU/shift/compare/multiply pipeline plus optional divider (EXEC_DIV_EN).
// Latency: non-divide ops MUL_STAGES+1 edges to out (out_valid after edge t+MUL_STAGES); divide DATA_WIDTH+2.
// Backpressure: in_ready drops only while the divider is in CALC/FIX; no backpressure on the result bus.
module int_exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MUL_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXEC_OP_W-1:0]  in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [ID_WIDTH-1:0]   in_tag,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_tag,
    output logic                  out_err
);
    localparam int SHW = $clog2(DATA_WIDTH);

    exec_op_e                w_op;
    logic                    w_accept;
    logic                    w_pipe_en;
    logic                    w_a_sgn;
    logic                    w_b_sgn;
    logic [SHW-1:0]          w_shamt;
    logic [2*DATA_WIDTH-1:0] w_a_ext;
    logic [2*DATA_WIDTH-1:0] w_b_ext;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_alu_res;
    logic                    w_alu_err;

    logic                    r_pv [MUL_STAGES];
    logic [DATA_WIDTH-1:0]   r_pd [MUL_STAGES];
    logic [ID_WIDTH-1:0]     r_pt [MUL_STAGES];
    logic                    r_pe [MUL_STAGES];
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [ID_WIDTH-1:0]     r_out_tag;
    logic                    r_out_err;

    assign w_op     = exec_op_e'(in_op);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_shamt  = in_b[SHW-1:0];

    // Single-cycle result for every non-divide op; the register chain behind it can be retimed.
    always_comb begin
        w_a_sgn   = (w_op == OP_MULH) || (w_op == OP_MULHSU);
        w_b_sgn   = (w_op == OP_MULH);
        w_a_ext   = {{DATA_WIDTH{w_a_sgn & in_a[DATA_WIDTH-1]}}, in_a};
        w_b_ext   = {{DATA_WIDTH{w_b_sgn & in_b[DATA_WIDTH-1]}}, in_b};
        w_prod    = w_a_ext * w_b_ext;
        w_alu_res = '0;
        w_alu_err = 1'b0;
        case (w_op)
            OP_ADD:    w_alu_res = in_a + in_b;
            OP_SUB:    w_alu_res = in_a - in_b;
            OP_SLL:    w_alu_res = in_a << w_shamt;
            OP_SRL:    w_alu_res = in_a >> w_shamt;
            OP_SRA:    w_alu_res = $signed(in_a) >>> w_shamt;
            OP_SLT:    w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU:   w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_XOR:    w_alu_res = in_a ^ in_b;
            OP_OR:     w_alu_res = in_a | in_b;
            OP_AND:    w_alu_res = in_a & in_b;
            OP_LUI:    w_alu_res = in_b;
            OP_MUL:    w_alu_res = w_prod[DATA_WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  w_alu_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            // Divides only reach this path when no divider is built.
            OP_DIV,
            OP_DIVU,
            OP_REM,
            OP_REMU:   w_alu_err = 1'b1;
            default:   w_alu_res = '0;
        endcase
    end

    // Valid chain: flush and reset both drop everything in flight, including the output stage.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            for (int i = 0; i < MUL_STAGES; i++) r_pv[i] <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_pv[0] <= w_pipe_en;
            for (int i = 1; i < MUL_STAGES; i++) r_pv[i] <= r_pv[i-1];
            r_out_valid <= r_pv[MUL_STAGES-1];
        end
    end

    // Payload chain; qualified only by the valid chain above.
    always_ff @(posedge clk) begin
        r_pd[0] <= w_alu_res;
        r_pt[0] <= in_tag;
        r_pe[0] <= w_alu_err;
        for (int i = 1; i < MUL_STAGES; i++) begin
            r_pd[i] <= r_pd[i-1];
            r_pt[i] <= r_pt[i-1];
            r_pe[i] <= r_pe[i-1];
        end
    end

    // Output stage payload: holds the last result so the bus stays quiet between results.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_out_err  <= 1'b0;
        end else if (r_pv[MUL_STAGES-1]) begin
            r_out_data <= r_pd[MUL_STAGES-1];
            r_out_tag  <= r_pt[MUL_STAGES-1];
            r_out_err  <= r_pe[MUL_STAGES-1];
        end
    end

`ifdef EXEC_DIV_EN
    logic                  w_div_start;
    logic                  w_div_busy;
    logic                  w_div_done;
    logic [DATA_WIDTH-1:0] w_div_result;
    logic [ID_WIDTH-1:0]   r_div_tag;

    assign w_div_start = w_accept && is_div(w_op);
    assign w_pipe_en   = w_accept && !is_div(w_op);

    int_divider #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .i_flush  (flush),
        .i_start  (w_div_start),
        .i_signed ((w_op == OP_DIV) || (w_op == OP_REM)),
        .i_rem    ((w_op == OP_REM) || (w_op == OP_REMU)),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_result (w_div_result)
    );

    // Remember the divide's tag; only one divide is ever outstanding.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div_tag <= '0;
        end else if (w_div_start) begin
            r_div_tag <= in_tag;
        end
    end

    // Older pipeline results always drain before DONE, so the divider owns the bus in DONE.
    assign in_ready  = !w_div_busy;
    assign out_valid = r_out_valid | w_div_done;
    assign out_data  = w_div_done ? w_div_result : r_out_data;
    assign out_tag   = w_div_done ? r_div_tag : r_out_tag;
    assign out_err   = w_div_done ? 1'b0 : r_out_err;
`else
    assign w_pipe_en = w_accept;
    assign in_ready  = 1'b1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
`endif

endmodule

// File: tb/tb_int_exec_unit.sv
// Scoreboard bench for int_exec_unit: directed vectors, expected results queued at issue.
// Latency: checks exact result cycle against issue edge.
// Backpressure: waits on in_ready (bounded) before issuing divides.
module tb_int_exec_unit;
    import exec_pkg::*;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MS = 2;
    localparam int DLAT = DW + 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_op = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [IW-1:0] in_tag = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_tag;
    logic          out_err;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] tag;
        logic          err;
        int            at;
    } exp_t;

    typedef struct {
        exec_op_e      op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
    } vec_t;

    exp_t q[$];
    exp_t mon_e;
    vec_t alu_v[16];
    vec_t div_v[11];

    int_exec_unit #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MUL_STAGES (MS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every result on the bus must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: actual data=%0h tag=%0h, expected no result (cycle %0d)",
                         out_data, out_tag, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("res_data", {32'd0, out_data}, {32'd0, mon_e.d});
                chk("res_tag", {60'd0, out_tag}, {60'd0, mon_e.tag});
                chk("res_err", {63'd0, out_err}, {63'd0, mon_e.err});
                chk("res_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic drive(input exec_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [IW-1:0] tag);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // Clock the offered op in; optionally queue its expected result lat edges later.
    task automatic step(input bit push, input logic [DW-1:0] d, input logic e, input int lat);
        exp_t x;
        @(posedge clk);
        #1;
        if (push) begin
            x.d   = d;
            x.tag = in_tag;
            x.err = e;
            x.at  = cyc + lat;
            q.push_back(x);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        alu_v[0]  = '{OP_SUB,    32'd3,        32'd5,        32'hFFFFFFFE};
        alu_v[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        alu_v[2]  = '{OP_SRA,    32'h80000000, 32'd4,        32'hF8000000};
        alu_v[3]  = '{OP_SRL,    32'h80000000, 32'd4,        32'h08000000};
        alu_v[4]  = '{OP_SLL,    32'd1,        32'h21,       32'd2};
        alu_v[5]  = '{OP_SLT,    32'hFFFFFFFF, 32'd1,        32'd1};
        alu_v[6]  = '{OP_SLT,    32'd1,        32'hFFFFFFFF, 32'd0};
        alu_v[7]  = '{OP_SLTU,   32'd1,        32'hFFFFFFFF, 32'd1};
        alu_v[8]  = '{OP_XOR,    32'hF0F0,     32'hFF00,     32'h0FF0};
        alu_v[9]  = '{OP_OR,     32'hF0F0,     32'h0F0F,     32'hFFFF};
        alu_v[10] = '{OP_AND,    32'hF0F0,     32'hFF00,     32'hF000};
        alu_v[11] = '{OP_LUI,    32'd0,        32'h12345000, 32'h12345000};
        alu_v[12] = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
        alu_v[13] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        alu_v[14] = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        alu_v[15] = '{OP_ADD,    32'hFFFFFFFF, 32'd1,        32'd0};

        div_v[0]  = '{OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        div_v[1]  = '{OP_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF};
        div_v[2]  = '{OP_REMU, 32'h1234,     32'd0,        32'h1234};
        div_v[3]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        div_v[4]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0};
        div_v[5]  = '{OP_DIVU, 32'd100,      32'd7,        32'd14};
        div_v[6]  = '{OP_REMU, 32'd100,      32'd7,        32'd2};
        div_v[7]  = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3};
        div_v[8]  = '{OP_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF};
        div_v[9]  = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        div_v[10] = '{OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single ADD, latency MS.
        drive(OP_ADD, 32'd5, 32'd7, 4'd3);
        step(1'b1, 32'd12, 1'b0, MS);
        repeat (4) @(negedge clk);

        // Back-to-back ALU/shift/compare/multiply vectors.
        for (int i = 0; i < 16; i++) begin
            drive(alu_v[i].op, alu_v[i].a, alu_v[i].b, IW'(i));
            step(1'b1, alu_v[i].r, 1'b0, MS);
        end
        repeat (5) @(negedge clk);

`ifdef EXEC_DIV_EN
        // DIV -7/2: in_ready low through the iterations, result after edge t+DW+2.
        drive(OP_DIV, 32'hFFFFFFF9, 32'd2, 4'd5);
        step(1'b1, 32'hFFFFFFFD, 1'b0, DLAT);
        t = cyc;
        @(negedge clk);
        for (int i = 1; i <= DLAT - 1; i++) begin
            @(negedge clk);
            chk("rdy_low_in_div", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        chk("rdy_after_div_cycle", cyc, t + DLAT);
        chk("rdy_after_div", {63'd0, in_ready}, 64'd1);

        // Further divides incl. divide-by-zero and signed overflow.
        for (int i = 0; i < 11; i++) begin
            wait_ready();
            drive(div_v[i].op, div_v[i].a, div_v[i].b, IW'(i + 4));
            step(1'b1, div_v[i].r, 1'b0, DLAT);
        end
        wait_ready();
        repeat (2) @(negedge clk);

        // Flush kills a MUL in the pipe and the DIV behind it.
        drive(OP_MUL, 32'd3, 32'd4, 4'd8);
        step(1'b0, '0, 1'b0, 0);
        drive(OP_DIV, 32'd100, 32'd3, 4'd9);
        step(1'b0, '0, 1'b0, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush1_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush1_in_ready", {63'd0, in_ready}, 64'd1);

        // Flush ten cycles into a DIV.
        drive(OP_DIV, 32'd100, 32'd3, 4'd10);
        step(1'b0, '0, 1'b0, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush2_in_ready", {63'd0, in_ready}, 64'd1);
`else
        // Divides without a divider: error result through the normal pipeline, never stalling.
        t = cyc;
        drive(OP_DIVU, 32'd10, 32'd2, 4'd7);
        step(1'b1, 32'd0, 1'b1, MS);
        drive(OP_DIV, 32'hFFFFFFF9, 32'd2, 4'd8);
        step(1'b1, 32'd0, 1'b1, MS);
        drive(OP_REM, 32'd9, 32'd4, 4'd9);
        step(1'b1, 32'd0, 1'b1, MS);
        drive(OP_REMU, 32'd9, 32'd4, 4'd10);
        step(1'b1, 32'd0, 1'b1, MS);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nodiv_in_ready", {63'd0, in_ready}, 64'd1);
        end
        chk("nodiv_elapsed", cyc, t + 7);

        // Flush kills a MUL in the pipe.
        drive(OP_MUL, 32'd3, 32'd4, 4'd8);
        step(1'b0, '0, 1'b0, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush1_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush1_in_ready", {63'd0, in_ready}, 64'd1);
`endif

        // Op offered in the flush cycle is discarded.
        drive(OP_ADD, 32'd1, 32'd1, 4'd12);
        flush = 1'b1;
        step(1'b0, '0, 1'b0, 0);
        flush = 1'b0;
        repeat (4) @(negedge clk);

        // Normal op after flush.
        drive(OP_ADD, 32'd20, 32'd22, 4'd11);
        step(1'b1, 32'd42, 1'b0, MS);

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
